// File: rtl/pc_fetch_ctrl.sv
// PC/fetch sequencer: one imem read in flight, valid/ready hand-off to decode, ALU branch redirect.
// Optional ALIGN_CHECK_EN adds align_err and halts on misaligned branch targets.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt_req,
`ifdef ALIGN_CHECK_EN
  output logic        align_err,
`endif
  output logic        halted
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD, S_HALT} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic        r_req, w_req_nx;
  logic [31:0] r_addr, w_addr_nx;
  logic        r_valid, w_valid_nx;
  logic [31:0] r_instr, w_instr_nx;
  logic [31:0] r_instr_pc, w_instr_pc_nx;
  logic        r_halted, w_halted_nx;
  logic        w_err_q, w_err_nx;
  logic        w_redirect, w_bad, w_jump;

  assign w_redirect = br_valid & br_taken;

`ifdef ALIGN_CHECK_EN
  logic r_align_err;
  assign w_bad     = w_redirect & (|br_target[1:0]);
  assign w_err_q   = r_align_err;
  assign align_err = r_align_err;
`else
  assign w_bad     = 1'b0;
  assign w_err_q   = 1'b0;
`endif
  assign w_jump = w_redirect & ~w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_req      <= w_req_nx;
      r_addr     <= w_addr_nx;
      r_valid    <= w_valid_nx;
      r_instr    <= w_instr_nx;
      r_instr_pc <= w_instr_pc_nx;
      r_halted   <= w_halted_nx;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_align_err <= 1'b0;
    else        r_align_err <= w_err_nx;
  end
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_req_nx      = r_req;
    w_addr_nx     = r_addr;
    w_valid_nx    = r_valid;
    w_instr_nx    = r_instr;
    w_instr_pc_nx = r_instr_pc;
    w_halted_nx   = r_halted;
    w_err_nx      = w_err_q;
    unique case (r_state)
      S_IDLE: begin
        w_state_nx = S_REQ;
        w_req_nx   = 1'b1;
        w_addr_nx  = r_pc;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (w_bad) begin
            w_state_nx  = S_HALT;
            w_req_nx    = 1'b0;
            w_halted_nx = 1'b1;
            w_err_nx    = 1'b1;
          end else begin
            if (w_jump) w_pc_nx = br_target;
            if (halt_req) begin
              w_state_nx  = S_HALT;
              w_req_nx    = 1'b0;
              w_halted_nx = 1'b1;
            end else if (w_jump) begin
              w_addr_nx = br_target;
            end else begin
              w_state_nx    = S_HOLD;
              w_instr_nx    = imem_rdata;
              w_instr_pc_nx = r_addr;
              w_valid_nx    = 1'b1;
              w_req_nx      = 1'b0;
            end
          end
        end else if (w_redirect) begin
          // The outstanding read is never abandoned; its data is dropped in DRAIN.
          w_state_nx = S_DRAIN;
          if (w_bad) w_err_nx = 1'b1;
          else       w_pc_nx  = br_target;
        end
      end
      S_DRAIN: begin
        if (w_bad)       w_err_nx = 1'b1;
        else if (w_jump) w_pc_nx  = br_target;
        if (imem_ack) begin
          if (w_err_nx || halt_req) begin
            w_state_nx  = S_HALT;
            w_req_nx    = 1'b0;
            w_halted_nx = 1'b1;
          end else begin
            w_state_nx = S_REQ;
            w_addr_nx  = w_pc_nx;
          end
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_valid_nx = 1'b0;
          if (w_bad) begin
            w_state_nx  = S_HALT;
            w_halted_nx = 1'b1;
            w_err_nx    = 1'b1;
          end else begin
            w_pc_nx = br_target;
            if (halt_req) begin
              w_state_nx  = S_HALT;
              w_halted_nx = 1'b1;
            end else begin
              w_state_nx = S_REQ;
              w_req_nx   = 1'b1;
              w_addr_nx  = br_target;
            end
          end
        end else if (halt_req) begin
          w_valid_nx  = 1'b0;
          w_state_nx  = S_HALT;
          w_halted_nx = 1'b1;
        end else if (r_valid && id_ready) begin
          w_pc_nx    = r_pc + 32'(PC_STEP);
          w_state_nx = S_REQ;
          w_valid_nx = 1'b0;
          w_req_nx   = 1'b1;
          w_addr_nx  = r_pc + 32'(PC_STEP);
        end
      end
      S_HALT: begin
        w_req_nx    = 1'b0;
        w_valid_nx  = 1'b0;
        w_halted_nx = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;

endmodule
